// File: rtl/elastic_buffer.sv
// Valid/ready elastic buffer: DEPTH-entry register FIFO with occupancy, almost-full,
// synchronous flush and optional full-passthrough acceptance. No combinational path data_in -> data_out.
module elastic_buffer #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4,
    parameter int AF_THRESH     = 3,
    parameter int FULL_PASSTHRU = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         data_in_valid,
    output logic                         data_in_ready,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         data_out_valid,
    input  logic                         data_out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg,  count_next;

    logic             full;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] wr_en;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full           = (count_reg == CNT_W'(DEPTH));
    assign data_out_valid = (count_reg != '0);
    assign data_out       = data_out_valid ? mem_reg[rd_ptr_reg] : '0;
    assign count          = count_reg;
    assign almost_full    = (count_reg >= CNT_W'(AF_THRESH));

    generate
        if (FULL_PASSTHRU != 0) begin : g_ready_passthru
            // When full, a word may enter in the same cycle the oldest one leaves.
            assign data_in_ready = !rst && !flush && (!full || data_out_ready);
        end else begin : g_ready_registered
            assign data_in_ready = !rst && !flush && !full;
        end
    endgenerate

    assign push = data_in_valid  && data_in_ready;
    assign pop  = data_out_valid && data_out_ready;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_next = ptr_inc(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is intentionally not reset; data_out masks stale entries while empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_reg[i] <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_elastic_buffer.sv
// Directed bench for elastic_buffer: three builds (DEPTH=4, DEPTH=4 passthrough, DEPTH=3) share one stimulus.
module tb_elastic_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] din;
    logic        vin;
    logic        oready;

    logic        rdy_a, val_a, af_a;
    logic [31:0] dout_a;
    logic [2:0]  cnt_a;
    logic        rdy_b, val_b, af_b;
    logic [31:0] dout_b;
    logic [2:0]  cnt_b;
    logic        rdy_c, val_c, af_c;
    logic [31:0] dout_c;
    logic [1:0]  cnt_c;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    elastic_buffer #(.DATA_WIDTH(32), .DEPTH(4), .AF_THRESH(3), .FULL_PASSTHRU(0)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .data_in(din), .data_in_valid(vin), .data_in_ready(rdy_a),
        .data_out(dout_a), .data_out_valid(val_a), .data_out_ready(oready),
        .count(cnt_a), .almost_full(af_a)
    );

    elastic_buffer #(.DATA_WIDTH(32), .DEPTH(4), .AF_THRESH(3), .FULL_PASSTHRU(1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .data_in(din), .data_in_valid(vin), .data_in_ready(rdy_b),
        .data_out(dout_b), .data_out_valid(val_b), .data_out_ready(oready),
        .count(cnt_b), .almost_full(af_b)
    );

    elastic_buffer #(.DATA_WIDTH(32), .DEPTH(3), .AF_THRESH(2), .FULL_PASSTHRU(0)) dut_c (
        .clk(clk), .rst(rst), .flush(flush),
        .data_in(din), .data_in_valid(vin), .data_in_ready(rdy_c),
        .data_out(dout_c), .data_out_valid(val_c), .data_out_ready(oready),
        .count(cnt_c), .almost_full(af_c)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        flush  = 1'b0;
        vin    = 1'b0;
        oready = 1'b0;
        din    = '0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held two cycles with producer valid
        rst = 1'b1; flush = 1'b0; vin = 1'b1; din = 32'h11; oready = 1'b0;
        tick();
        tick();
        check("rst_ready_a", rdy_a, 0);
        check("rst_ready_b", rdy_b, 0);
        check("rst_valid_a", val_a, 0);
        check("rst_count_a", cnt_a, 0);
        check("rst_dout_a", dout_a, 0);
        check("rst_af_a", af_a, 0);
        rst = 1'b0; vin = 1'b0;
        #1;
        check("post_rst_ready_a", rdy_a, 1);

        // Fill with consumer stalled
        vin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 32'hA0 + i;
            #1;
            check($sformatf("fill_ready_a_%0d", i), rdy_a, 1);
            tick();
            check($sformatf("fill_count_a_%0d", i), cnt_a, i + 1);
            check($sformatf("fill_af_a_%0d", i), af_a, (i + 1) >= 3);
        end
        din = 32'hA4;
        #1;
        check("full_ready_a", rdy_a, 0);
        check("full_ready_b_stalled", rdy_b, 0);
        tick();
        check("full_hold_count_a", cnt_a, 4);
        check("full_head_a", dout_a, 32'hA0);

        // Drain in order
        vin = 1'b0; oready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("drain_valid_a_%0d", i), val_a, 1);
            check($sformatf("drain_dout_a_%0d", i), dout_a, 32'hA0 + i);
            tick();
        end
        check("drained_valid_a", val_a, 0);
        check("drained_count_a", cnt_a, 0);
        check("drained_dout_a", dout_a, 0);
        vin = 1'b1; din = 32'hA4; oready = 1'b0;
        tick();
        vin = 1'b0;
        check("resume_dout_a", dout_a, 32'hA4);
        check("resume_count_a", cnt_a, 1);

        // Streaming, one word per cycle, pointers wrap several times
        do_reset();
        check("midrst_count_a", cnt_a, 0);
        check("midrst_valid_a", val_a, 0);
        vin = 1'b1; oready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            din = 32'h100 + k;
            tick();
            check($sformatf("stream_cnt_a_%0d", k), cnt_a, 1);
            check($sformatf("stream_dout_a_%0d", k), dout_a, 32'h100 + k);
            check($sformatf("stream_cnt_c_%0d", k), cnt_c, 1);
            check($sformatf("stream_dout_c_%0d", k), dout_c, 32'h100 + k);
        end
        vin = 1'b0;
        tick();
        check("stream_end_count_a", cnt_a, 0);
        check("stream_end_count_c", cnt_c, 0);

        // Full passthrough versus registered ready
        do_reset();
        vin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 32'hB0 + i;
            tick();
        end
        check("pt_full_count_b", cnt_b, 4);
        check("pt_full_count_c", cnt_c, 3);
        check("pt_full_af_c", af_c, 1);
        din = 32'hB4; oready = 1'b1;
        #1;
        check("pt_ready_a", rdy_a, 0);
        check("pt_ready_b", rdy_b, 1);
        tick();
        check("pt_count_a", cnt_a, 3);
        check("pt_count_b", cnt_b, 4);
        check("pt_head_a", dout_a, 32'hB1);
        check("pt_head_b", dout_b, 32'hB1);
        vin = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            check($sformatf("pt_drain_b_%0d", j), dout_b, 32'hB1 + j);
            check($sformatf("pt_drain_valid_a_%0d", j), val_a, j < 3);
            tick();
        end
        check("pt_drained_valid_b", val_b, 0);

        // Flush with three entries stored
        do_reset();
        vin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 32'hC0 + i;
            tick();
        end
        check("fl_pre_count_a", cnt_a, 3);
        flush = 1'b1; din = 32'hEE;
        #1;
        check("fl_ready_a", rdy_a, 0);
        check("fl_ready_b", rdy_b, 0);
        check("fl_valid_a", val_a, 1);
        tick();
        flush = 1'b0; din = 32'h55;
        check("fl_count_a", cnt_a, 0);
        check("fl_valid_a_after", val_a, 0);
        tick();
        vin = 1'b0;
        check("fl_first_out_a", dout_a, 32'h55);
        check("fl_first_count_a", cnt_a, 1);
        check("fl_first_out_c", dout_c, 32'h55);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
